// File: rtl/fpu_dd192_scheduler_pkg.sv
// Shared types and constants for the FPU request scheduler.
// Opcodes match the encoding of the shared Floating_Point_Unit.
package fpu_dd192_scheduler_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_ROOT = 3'b100;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } fpu_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fpu_sched_state_e;

    // Encodings 101..111 have no FPU operation behind them.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op > OP_ROOT;
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above the
// pointer, searching upward and wrapping, and reports it one-hot and as an index.
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

    int              pos;
    logic [ID_W-1:0] pos_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = 0;
        pos_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos     = (int'(ptr) + i) % NUM_REQ;
            pos_idx = pos[ID_W-1:0];
            if (!grant_vld && req[pos_idx]) begin
                grant_vld        = 1'b1;
                grant[pos_idx]   = 1'b1;
                grant_idx        = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fpu_dd192_scheduler.sv
// Time-shares one combinational FPU between NUM_REQ requesters: round-robin
// accept, hold operands for the op's settle time, return a tagged response.
module fpu_dd192_scheduler
    import fpu_dd192_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ADDSUB_CYCLES = 2,
    parameter int MULDIV_CYCLES = 4,
    parameter int ROOT_CYCLES   = 6,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][31:0]  req_op_a,
    input  logic [NUM_REQ-1:0][31:0]  req_op_b,
    input  logic [NUM_REQ-1:0][2:0]   req_operation,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [31:0]               rsp_result,
    output logic                      rsp_overflow,
    output logic                      rsp_underflow,
    output logic                      rsp_illegal,
    output logic [31:0]               fpu_op_a,
    output logic [31:0]               fpu_op_b,
    output logic [2:0]                fpu_operation,
    input  logic [31:0]               fpu_result,
    input  logic                      fpu_overflow,
    input  logic                      fpu_underflow,
    output logic                      busy,
    output fpu_sched_state_e          dbg_state
);

    localparam int MAX_LAT_A = (ADDSUB_CYCLES > MULDIV_CYCLES) ? ADDSUB_CYCLES : MULDIV_CYCLES;
    localparam int MAX_LAT   = (MAX_LAT_A > ROOT_CYCLES) ? MAX_LAT_A : ROOT_CYCLES;
    localparam int CNT_W     = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

    // Handshake: a requester is accepted on a rising edge where its
    // req_valid and req_ready are both high; a response is consumed on a
    // rising edge where rsp_valid and rsp_ready are both high. req_valid
    // may drop at any time before acceptance without side effects.

    fpu_sched_state_e   state;
    fpu_req_t           cur;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic [2:0]         grant_op;
    logic [ID_W-1:0]    ptr_next;

    fpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Settle count minus one, so the counter reaches zero on the last
    // cycle the FPU inputs need to be held.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] op);
        logic [CNT_W-1:0] v;
        case (op)
            OP_ADD, OP_SUB: v = CNT_W'(ADDSUB_CYCLES - 1);
            OP_MUL, OP_DIV: v = CNT_W'(MULDIV_CYCLES - 1);
            default:        v = CNT_W'(ROOT_CYCLES - 1);
        endcase
        return v;
    endfunction

    assign grant_op = req_operation[grant_idx];
    assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    // Gated by rst_n so no requester sees a grant while reset is held.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;

    assign fpu_op_a      = cur.a;
    assign fpu_op_b      = cur.b;
    assign fpu_operation = cur.op;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur           <= '0;
            cur_id        <= '0;
            ptr           <= '0;
            cnt           <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cur.a  <= req_op_a[grant_idx];
                        cur.b  <= req_op_b[grant_idx];
                        cur.op <= grant_op;
                        cur_id <= grant_idx;
                        ptr    <= ptr_next;
                        cnt    <= lat_m1(grant_op);
                        if (op_is_illegal(grant_op)) begin
                            // No FPU work: answer straight away with a zero result.
                            rsp_valid     <= 1'b1;
                            rsp_id        <= grant_idx;
                            rsp_result    <= '0;
                            rsp_overflow  <= 1'b0;
                            rsp_underflow <= 1'b0;
                            rsp_illegal   <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_valid     <= 1'b1;
                        rsp_id        <= cur_id;
                        rsp_result    <= fpu_result;
                        rsp_overflow  <= fpu_overflow;
                        rsp_underflow <= fpu_underflow;
                        rsp_illegal   <= 1'b0;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
